// File: rtl/nv_ram_pkg.sv
// Shared definitions for the parametrised rwsp RAM model.
//   clr_state_e          : clear-sequencer state encoding
//   lw()                 : bits per write-mask lane
//   NV_RAM_CHECK_PARAMS  : elaboration-time legality check on DEPTH/MW
`ifndef NV_RAM_PKG_SV
`define NV_RAM_PKG_SV

`define NV_RAM_CHECK_PARAMS(DW_, AW_, DEPTH_, MW_) \
  if ((DEPTH_) < 2 || (DEPTH_) > (1 << (AW_)) || (MW_) < 1 || ((DW_) % (MW_)) != 0) begin : g_bad_params \
    $fatal(1, "nv_ram: illegal DEPTH or MW parameter"); \
  end

package nv_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  function automatic int lw(input int dw, input int mw);
    return dw / mw;
  endfunction

endpackage

`endif

// File: rtl/nv_ram_clr_seq.sv
// Reset-time clear sequencer: walks every entry once, writing zero, then
// parks in READY until the next reset.
// Ports:
//   clk_i, rst_ni  : clock, async active-low reset
//   clr_we_o       : array clear write strobe (high for the whole CLEAR phase)
//   clr_wa_o       : array clear write address
//   init_busy_o    : registered busy flag, high while clearing
//
// state | meaning
// CLEAR | zeroing M[cnt] each cycle, external traffic ignored
// READY | normal operation, terminal until reset
module nv_ram_clr_seq
  import nv_ram_pkg::*;
#(
  parameter int AW         = 7,
  parameter int DEPTH      = 128,
  parameter int INIT_CLEAR = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_wa_o,
  output logic          init_busy_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_e    state_q;
  logic [AW-1:0] cnt_q;
  logic          busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= (INIT_CLEAR != 0) ? CLEAR : READY;
      cnt_q   <= '0;
      busy_q  <= (INIT_CLEAR != 0);
    end else if (state_q == CLEAR) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_q <= READY;
        busy_q  <= 1'b0;
      end
    end
  end

  assign clr_we_o    = (state_q == CLEAR);
  assign clr_wa_o    = cnt_q;
  assign init_busy_o = busy_q;

endmodule

// File: rtl/nv_ram_rwsp_param.sv
// Parametrised 1R/1W RAM model with registered read address, ore-gated
// output register, lane write mask, optional write-first bypass and a
// reset-time clear sequence.
// Ports:
//   nvdla_core_clk, nvdla_core_rstn : clock, async active-low reset
//   ra, re                          : read address and capture enable
//   ore, dout, dout_vld             : output load enable, data, valid
//   wa, we, wmask, di               : write address, enable, lane mask, data
//   init_busy                       : clear sequence in progress
//   pwrbus_ram_pd                   : power control, functionally unused
module nv_ram_rwsp_param
  import nv_ram_pkg::*;
#(
  parameter int DW         = 6,
  parameter int AW         = 7,
  parameter int DEPTH      = 128,
  parameter int MW         = 1,
  parameter int BYPASS     = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic [AW-1:0] ra,
  input  logic          re,
  input  logic          ore,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [MW-1:0] wmask,
  input  logic [DW-1:0] di,
  output logic          init_busy,
  input  logic [31:0]   pwrbus_ram_pd
);

  `NV_RAM_CHECK_PARAMS(DW, AW, DEPTH, MW)

  localparam int        LW      = lw(DW, MW);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] ra_q;
  logic          ra_vld_q;
  logic [DW-1:0] dout_q;
  logic          dout_vld_q;

  logic          clr_we;
  logic [AW-1:0] clr_wa;
  logic          ready;
  logic          wa_ok;
  logic          ra_ok;
  logic          collide;
  logic [DW-1:0] lane_bits;
  logic [DW-1:0] rd_raw;
  logic [DW-1:0] rdata;
  logic          unused_pwr;

  assign unused_pwr = ^pwrbus_ram_pd;

  nv_ram_clr_seq #(
    .AW         (AW),
    .DEPTH      (DEPTH),
    .INIT_CLEAR (INIT_CLEAR)
  ) u_clr_seq (
    .clk_i       (nvdla_core_clk),
    .rst_ni      (nvdla_core_rstn),
    .clr_we_o    (clr_we),
    .clr_wa_o    (clr_wa),
    .init_busy_o (init_busy)
  );

  assign ready = ~clr_we;
  assign wa_ok = {1'b0, wa} < DEPTH_W;
  assign ra_ok = {1'b0, ra_q} < DEPTH_W;

  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < MW; i++) begin
      lane_bits[i*LW +: LW] = {LW{wmask[i]}};
    end
  end

  // Out-of-range reads return zero and never take the bypass path.
  assign rd_raw  = ra_ok ? mem[ra_q] : '0;
  assign collide = (BYPASS != 0) && we && ra_ok && (wa == ra_q);
  assign rdata   = collide ? ((rd_raw & ~lane_bits) | (di & lane_bits)) : rd_raw;

  // Array is deliberately not reset; the clear sequencer owns the write
  // port while busy.
  always_ff @(posedge nvdla_core_clk) begin
    if (clr_we) begin
      mem[clr_wa] <= '0;
    end else if (we && wa_ok) begin
      for (int i = 0; i < MW; i++) begin
        if (wmask[i]) mem[wa][i*LW +: LW] <= di[i*LW +: LW];
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      ra_q       <= '0;
      ra_vld_q   <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else if (ready) begin
      if (re) begin
        ra_q     <= ra;
        ra_vld_q <= 1'b1;
      end
      // ore samples the pre-edge ra_q, so re and ore together read the old address.
      if (ore) begin
        dout_q     <= rdata;
        dout_vld_q <= ra_vld_q;
      end
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// Bench for nv_ram_rwsp_param. Three configurations share one stimulus:
//   u0: DW=6 DEPTH=128 MW=1 BYPASS=0
//   u1: DW=8 DEPTH=100 MW=2 BYPASS=0
//   u2: DW=8 DEPTH=128 MW=2 BYPASS=1
module tb_nv_ram_rwsp_param;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic [6:0]  ra   = '0;
  logic        re   = 1'b0;
  logic        ore  = 1'b0;
  logic [6:0]  wa   = '0;
  logic        we   = 1'b0;
  logic [1:0]  wmask = '0;
  logic [7:0]  di   = '0;
  logic [31:0] pwr  = '0;

  logic [5:0]  dout0;
  logic [7:0]  dout1, dout2;
  logic        vld0, vld1, vld2, busy0, busy1, busy2;

  always #5 clk = ~clk;

  nv_ram_rwsp_param #(.DW(6), .AW(7), .DEPTH(128), .MW(1), .BYPASS(0), .INIT_CLEAR(1)) u0 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .ra(ra), .re(re), .ore(ore),
    .dout(dout0), .dout_vld(vld0), .wa(wa), .we(we), .wmask(wmask[0:0]), .di(di[5:0]),
    .init_busy(busy0), .pwrbus_ram_pd(pwr));

  nv_ram_rwsp_param #(.DW(8), .AW(7), .DEPTH(100), .MW(2), .BYPASS(0), .INIT_CLEAR(1)) u1 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .ra(ra), .re(re), .ore(ore),
    .dout(dout1), .dout_vld(vld1), .wa(wa), .we(we), .wmask(wmask), .di(di),
    .init_busy(busy1), .pwrbus_ram_pd(pwr));

  nv_ram_rwsp_param #(.DW(8), .AW(7), .DEPTH(128), .MW(2), .BYPASS(1), .INIT_CLEAR(1)) u2 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .ra(ra), .re(re), .ore(ore),
    .dout(dout2), .dout_vld(vld2), .wa(wa), .we(we), .wmask(wmask), .di(di),
    .init_busy(busy2), .pwrbus_ram_pd(pwr));

  logic [7:0] d_dout [3];
  logic       d_vld  [3];
  logic       d_busy [3];
  assign d_dout[0] = {2'b00, dout0};
  assign d_dout[1] = dout1;
  assign d_dout[2] = dout2;
  assign d_vld[0]  = vld0;
  assign d_vld[1]  = vld1;
  assign d_vld[2]  = vld2;
  assign d_busy[0] = busy0;
  assign d_busy[1] = busy1;
  assign d_busy[2] = busy2;

  int P_DW    [3] = '{6, 8, 8};
  int P_DEPTH [3] = '{128, 100, 128};
  int P_MW    [3] = '{1, 2, 2};
  int P_BYP   [3] = '{0, 0, 1};

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory is all-zero once the clear completes, and
  // nothing external has an effect until DEPTH clock edges after release.
  logic [7:0] m_mem  [3][128];
  logic [6:0] m_ra   [3];
  bit         m_rav  [3];
  logic [7:0] m_dout [3];
  bit         m_dv   [3];
  int         m_k    [3];

  function automatic logic [7:0] lanebits(input int dw, input int mw, input logic [1:0] wm);
    logic [7:0] r;
    r = '0;
    for (int b = 0; b < dw; b++) if (wm[b / (dw / mw)]) r[b] = 1'b1;
    return r;
  endfunction

  logic [7:0] dm, lb, rd;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) begin
        m_ra[i] = '0; m_rav[i] = 1'b0; m_dout[i] = '0; m_dv[i] = 1'b0; m_k[i] = 0;
        for (int a = 0; a < 128; a++) m_mem[i][a] = '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_k[i] < P_DEPTH[i]) begin
          m_k[i]++;
        end else begin
          dm = 8'hFF >> (8 - P_DW[i]);
          lb = lanebits(P_DW[i], P_MW[i], wmask) & dm;
          rd = (int'(m_ra[i]) < P_DEPTH[i]) ? m_mem[i][m_ra[i]] : 8'h00;
          if (P_BYP[i] != 0 && we && wa == m_ra[i] && int'(wa) < P_DEPTH[i])
            rd = (rd & ~lb) | (di & lb);
          if (ore) begin
            m_dout[i] = rd & dm;
            m_dv[i]   = m_rav[i];
          end
          if (we && int'(wa) < P_DEPTH[i])
            m_mem[i][wa] = ((m_mem[i][wa] & ~lb) | (di & lb)) & dm;
          if (re) begin
            m_ra[i]  = ra;
            m_rav[i] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d dout", i), 32'(d_dout[i]), 32'(m_dout[i]));
        chk($sformatf("u%0d dout_vld", i), 32'(d_vld[i]), 32'(m_dv[i]));
        chk($sformatf("u%0d init_busy", i), 32'(d_busy[i]), 32'(m_k[i] < P_DEPTH[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    re = 1'b0; ore = 1'b0; we = 1'b0;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d, input logic [1:0] m);
    we = 1'b1; wa = a; di = d; wmask = m;
    tick();
    we = 1'b0;
  endtask

  task automatic do_read(input logic [6:0] a);
    ra = a; re = 1'b1;
    tick();
    re = 1'b0; ore = 1'b1;
    tick();
    ore = 1'b0;
  endtask

  function automatic logic [6:0] raddr();
    case ($urandom_range(0, 2))
      0:       return 7'($urandom_range(0, 15));
      1:       return 7'($urandom_range(96, 111));
      default: return 7'($urandom_range(0, 127));
    endcase
  endfunction

  task automatic rand_inputs();
    re = 1'($urandom_range(0, 1)); ore = 1'($urandom_range(0, 1));
    we = 1'($urandom_range(0, 1)); wmask = 2'($urandom_range(0, 3));
    ra = raddr(); wa = raddr(); di = 8'($urandom);
  endtask

  task automatic measure_busy(input bit rnd);
    int n0, n1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      if (rnd && i < 120) rand_inputs(); else idle();
      tick();
    end
    idle();
    chk("busy cycles DEPTH=128", 32'(n0), 32'd128);
    chk("busy cycles DEPTH=100", 32'(n1), 32'd100);
  endtask

  initial begin
    tick();
    tick();
    chk_en = 1'b1;
    chk("reset dout", 32'(dout0), 32'h0);
    chk("reset dout_vld", 32'(vld0), 32'h0);
    chk("reset init_busy", 32'(busy0), 32'h1);

    rstn = 1'b1;
    measure_busy(1'b0);

    do_read(7'd0);
    chk("clear rd 0", 32'(dout0), 32'h0);
    chk("clear rd 0 vld", 32'(vld0), 32'h1);
    do_read(7'd64);
    chk("clear rd 64", 32'(dout0), 32'h0);
    chk("clear rd 64 vld", 32'(vld0), 32'h1);
    do_read(7'd127);
    chk("clear rd 127", 32'(dout0), 32'h0);
    chk("clear rd 127 vld", 32'(vld0), 32'h1);

    do_write(7'd5, 8'h2A, 2'b11);
    do_read(7'd5);
    chk("latency 2A", 32'(dout0), 32'h2A);
    tick(); tick(); tick();
    chk("hold 2A", 32'(dout0), 32'h2A);

    do_write(7'd3, 8'hFF, 2'b11);
    do_write(7'd3, 8'h00, 2'b01);
    do_read(7'd3);
    chk("mask u1", 32'(dout1), 32'hF0);
    chk("mask u2", 32'(dout2), 32'hF0);

    do_write(7'd9, 8'h11, 2'b11);
    ra = 7'd9; re = 1'b1;
    tick();
    re = 1'b0; ore = 1'b1; we = 1'b1; wa = 7'd9; di = 8'hAB; wmask = 2'b10;
    tick();
    we = 1'b0;
    chk("collision read-first", 32'(dout1), 32'h11);
    chk("collision write-first", 32'(dout2), 32'hA1);
    tick();
    ore = 1'b0;
    chk("after collision u1", 32'(dout1), 32'hA1);
    chk("after collision u2", 32'(dout2), 32'hA1);

    do_write(7'd110, 8'h3F, 2'b11);
    do_read(7'd110);
    chk("oor read u1", 32'(dout1), 32'h0);
    chk("oor read u1 vld", 32'(vld1), 32'h1);
    chk("oor in-range u0", 32'(dout0), 32'h3F);

    for (int c = 0; c < 2000; c++) begin
      rand_inputs();
      tick();
    end
    idle();

    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 40; c++) begin
      rand_inputs();
      tick();
    end
    rstn = 1'b0;
    idle();
    #1;
    chk("midclear dout", 32'(dout0), 32'h0);
    chk("midclear dout_vld", 32'(vld0), 32'h0);
    chk("midclear init_busy", 32'(busy0), 32'h1);
    tick();
    rstn = 1'b1;
    measure_busy(1'b1);
    do_read(7'd0);
    chk("post midclear rd 0", 32'(dout0), 32'h0);
    do_read(7'd9);
    chk("post midclear rd 9", 32'(dout0), 32'h0);

    for (int c = 0; c < 500; c++) begin
      rand_inputs();
      tick();
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nv_ram_rwsp_param.md
Name: nv_ram_rwsp_param

Overview:
- Parametrised successor of the fixed-size rwsp RAM models: one read port and one write port, with a registered read address and an ore-gated output register.
- Adds write lane masking, optional read-during-write bypass, a reset-time hardware clear sequencer, and an output valid flag.
- Used as a generic FPGA-model buffer for small NVDLA pipeline stores (CDMA/SDP/PDP-class buffers).

Parameters:
- DW, 6, data width in bits.
- AW, 7, address width.
- DEPTH, 128, number of entries; must satisfy 2 <= DEPTH <= 2^AW.
- MW, 1, write-mask lanes; DW % MW == 0; lane i covers bits [i*DW/MW +: DW/MW].
- BYPASS, 0, 1 = write-first forwarding on read/write collision; 0 = read-first (old data).
- INIT_CLEAR, 1, 1 = zero every entry after reset release; 0 = no clear, contents undefined.

Ports:
- nvdla_core_clk  in  1  clock.
- nvdla_core_rstn  in  1  asynchronous active-low reset.
- ra  in  AW  read address.
- re  in  1  read-address capture enable.
- ore  in  1  output-register load enable.
- dout  out  DW  registered read data.
- dout_vld  out  1  dout holds data loaded from a captured address.
- wa  in  AW  write address.
- we  in  1  write enable.
- wmask  in  MW  per-lane write enable; a lane is written only if we & wmask[i].
- di  in  DW  write data.
- init_busy  out  1  clear sequence in progress.
- pwrbus_ram_pd  in  32  power control; no functional effect in this model.

Behaviour:
- Asynchronous reset clears:
  - ra_d = 0, ra_vld = 0;
  - dout = 0, dout_vld = 0;
  - clear counter = 0;
  - FSM = CLEAR if INIT_CLEAR, else READY.
- Array contents are not reset.
- init_busy = 1 in CLEAR, 0 in READY. Its reset value is INIT_CLEAR.
- FSM CLEAR:
  - Each cycle writes all-zero to M[cnt], then cnt++.
  - When cnt == DEPTH-1 is written, go to READY.
  - CLEAR lasts exactly DEPTH cycles after rstn deasserts.
  - During CLEAR, external we, re and ore are ignored: no array write, ra_d/ra_vld hold, and dout/dout_vld hold at 0.
- FSM READY is terminal until the next reset. Reset asserted mid-CLEAR restarts CLEAR from address 0.
- Write (READY): at the clock edge with we = 1, each enabled lane of M[wa] takes the matching lane of di. Disabled lanes keep their value.
- Read address: at the edge with re = 1, ra_d <= ra and ra_vld <= 1. With re = 0, ra_d holds.
- Output register:
  - At the edge with ore = 1, dout <= rdata(ra_d) and dout_vld <= ra_vld.
  - With ore = 0, dout and dout_vld hold.
- Latency: re at edge N, ore at edge N+1 -> data on dout after edge N+1 (2 cycles from ra presentation).
- Re-read: ore with ra_d unchanged re-reads the current array content, so intervening writes to that address are reflected.
- Collision: we = 1 and wa == ra_d at the same edge as ore = 1.
  - BYPASS = 0: dout gets the pre-write contents.
  - BYPASS = 1: enabled lanes come from di, other lanes from M.
- Write at edge N to an address captured by re at edge N: the ore read at N+1 sees the new data in both modes, because the write has already completed.
- Out-of-range address (>= DEPTH):
  - write is dropped;
  - read returns all-zero, with dout_vld still following ra_vld;
  - no bypass is applied.
- Simultaneous re and ore at the same edge: ore uses the old ra_d; the new ra is captured for the next read.

Decomposition:
- Shared package nv_ram_pkg:
  - FSM state encoding: CLEAR = 1'b0, READY = 1'b1.
  - Lane-width function lw(DW, MW).
  - Parameter-legality check macro (fatal at elaboration on bad DEPTH or MW).
- One natural sub-module, nv_ram_clr_seq: the clear FSM and counter. It outputs clr_we, clr_wa and init_busy, which the top muxes onto the array write port.
- The array, bypass merge and output register stay in the top.

Test Plan:
- Reset/clear (DEPTH = 128, INIT_CLEAR = 1): release rstn, then poll.
  - Required: init_busy = 1 for exactly 128 cycles, then 0.
  - Reads of addresses 0, 64 and 127 then return 0 with dout_vld = 1.
- Basic latency:
  - Write 6'h2A @ 5.
  - re with ra = 5 at edge N, ore at N+1.
  - Required: dout = 6'h2A after N+1. With ore held low afterwards, dout holds 6'h2A.
- Mask (DW = 8, MW = 2):
  - M[3] = 8'hFF; write di = 8'h00 with wmask = 2'b01.
  - Required: read of address 3 gives 8'hF0.
- Collision (DW = 8, MW = 2), M[9] = 8'h11; in the same cycle: ra_d = 9, ore = 1, we = 1, wa = 9, di = 8'hAB, wmask = 2'b10.
  - Required with BYPASS = 0: dout = 8'h11.
  - Required with BYPASS = 1: dout = 8'hA1.
  - Next ore in either mode: dout = 8'hA1.
- Mid-clear reset:
  - Assert rstn low at clear cycle 40, then release.
  - Required: dout = 0, dout_vld = 0; init_busy stays 1 for a full 128 cycles.
  - Writes issued during CLEAR leave M unchanged: reads return 0.
- Out of range (DEPTH = 100, AW = 7):
  - Write 6'h3F @ 110, then read address 110.
  - Required: dout = 0. M[0..99] are unchanged.
